// File: rtl/mips_cpu_mem_pkg.sv
// mips_cpu_mem_pkg
// Shared types and helpers for the CPU memory-port arbiter.
//   t_mem_state   : arbiter sequencer states
//   FULL_BE       : byte-enable pattern for a whole 32-bit word
//   be_is_partial : true when a store touches some, but not all, byte lanes
package mips_cpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    LS_RD,
    RMW_RD,
    RMW_WR,
    LS_WR,
    DONE
  } t_mem_state;

  localparam logic [3:0] FULL_BE = 4'b1111;

  // An empty enable is not "partial": it is a no-op store that never
  // reaches the bus, so it must not be steered into the RMW path.
  function automatic logic be_is_partial(input logic [3:0] be);
    return (be != FULL_BE) && (be != 4'b0000);
  endfunction

endpackage

// File: rtl/mips_cpu_byte_merge.sv
// mips_cpu_byte_merge
// Purely combinational byte-lane merge, reusable by cache fill logic.
//   old_word : existing memory word
//   new_word : lane-aligned replacement data
//   be       : lane select, bit i picks new_word[8i+7:8i]
//   merged   : resulting word
module mips_cpu_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
// Serialises instruction-fetch and load/store requests onto one Avalon-MM
// master port. Data requests win over fetch. Partial stores become a
// read-modify-write so memory only sees full-word writes (when RMW_EN=1).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   if_req/if_addr               : fetch request (held until if_done)
//   if_rdata/if_done             : fetched word and completion pulse
//   ls_read/ls_write             : load/store request (held until ls_done)
//   ls_addr/ls_wdata/ls_be       : data address, lane-aligned data, lanes
//   ls_rdata/ls_done             : loaded word and completion pulse
//   stall                        : pipeline stall
//   avm_*                        : Avalon-MM master (zero read latency)
module mips_cpu_mem_arbiter
  import mips_cpu_mem_pkg::*;
#(
  parameter bit RMW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ls_read,
  input  logic        ls_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  t_mem_state  state_q, state_d;
  logic [31:0] addr_d, wdata_d, if_rdata_d, ls_rdata_d;
  logic        read_d, write_d, if_done_d, ls_done_d;
  logic [3:0]  be_d;
  logic [31:0] merged_word;

  // Word alignment drops the low address bits by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

  // The read half of an RMW is merged on the fly as it completes, so the
  // registered write-data becomes the word held for the write half.
  mips_cpu_byte_merge u_merge (
    .old_word (avm_readdata),
    .new_word (ls_wdata),
    .be       (ls_be),
    .merged   (merged_word)
  );

  // The pipeline may advance in the very cycle a done pulse is seen, so a
  // fetch still waiting behind a finished store does not hold the stall.
  assign stall = (if_req | ls_read | ls_write) & ~(if_done | ls_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= 4'b0000;
      if_rdata       <= '0;
      ls_rdata       <= '0;
      if_done        <= 1'b0;
      ls_done        <= 1'b0;
    end else begin
      state_q        <= state_d;
      avm_address    <= addr_d;
      avm_read       <= read_d;
      avm_write      <= write_d;
      avm_writedata  <= wdata_d;
      avm_byteenable <= be_d;
      if_rdata       <= if_rdata_d;
      ls_rdata       <= ls_rdata_d;
      if_done        <= if_done_d;
      ls_done        <= ls_done_d;
    end
  end

  // Bus outputs are only changed on command launch or completion, which
  // keeps them frozen for as long as the slave asserts waitrequest.
  // Done pulses are set on entry to DONE so they line up with that state.
  always_comb begin
    state_d    = state_q;
    addr_d     = avm_address;
    read_d     = avm_read;
    write_d    = avm_write;
    wdata_d    = avm_writedata;
    be_d       = avm_byteenable;
    if_rdata_d = if_rdata;
    ls_rdata_d = ls_rdata;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ls_read) begin
          state_d = LS_RD;
          addr_d  = {ls_addr[31:2], 2'b00};
          read_d  = 1'b1;
          be_d    = FULL_BE;
        end else if (ls_write) begin
          if (ls_be == 4'b0000) begin
            state_d   = DONE;
            ls_done_d = 1'b1;
          end else if (RMW_EN && be_is_partial(ls_be)) begin
            state_d = RMW_RD;
            addr_d  = {ls_addr[31:2], 2'b00};
            read_d  = 1'b1;
            be_d    = FULL_BE;
          end else begin
            state_d = LS_WR;
            addr_d  = {ls_addr[31:2], 2'b00};
            write_d = 1'b1;
            wdata_d = ls_wdata;
            be_d    = ls_be;
          end
        end else if (if_req) begin
          state_d = IF_RD;
          addr_d  = {if_addr[31:2], 2'b00};
          read_d  = 1'b1;
          be_d    = FULL_BE;
        end
      end
      IF_RD: begin
        if (!avm_waitrequest) begin
          state_d    = DONE;
          read_d     = 1'b0;
          if_rdata_d = avm_readdata;
          if_done_d  = 1'b1;
        end
      end
      LS_RD: begin
        if (!avm_waitrequest) begin
          state_d    = DONE;
          read_d     = 1'b0;
          ls_rdata_d = avm_readdata;
          ls_done_d  = 1'b1;
        end
      end
      RMW_RD: begin
        // Read and write halves are back to back with no idle cycle.
        if (!avm_waitrequest) begin
          state_d = RMW_WR;
          read_d  = 1'b0;
          write_d = 1'b1;
          wdata_d = merged_word;
          be_d    = FULL_BE;
        end
      end
      RMW_WR, LS_WR: begin
        if (!avm_waitrequest) begin
          state_d   = DONE;
          write_d   = 1'b0;
          ls_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

endmodule
